// File: rtl/multi_cycle_control_pkg.sv
// rtl/multi_cycle_control_pkg.sv - shared opcodes, state/class enums and ALUOp codes
package multi_cycle_control_pkg;

  // Full 11-bit opcodes (upper bits of the instruction word)
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  // Branch opcodes are shorter; the remaining low bits belong to the immediate
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASS  = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  // ILLEGAL is encoded as zero so a cleared class register reads as "nothing decoded"
  typedef enum logic [2:0] {
    CL_ILLEGAL, CL_LDUR, CL_STUR, CL_RTYPE, CL_CBZ, CL_CBNZ, CL_B
  } class_t;

endpackage

// File: rtl/multi_cycle_control_opcode_class_decode.sv
// rtl/multi_cycle_control_opcode_class_decode.sv - combinational opcode to instruction class map
module opcode_class_decode
  import multi_cycle_control_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int CBNZ_EN  = 0
) (
  input  logic [OPCODE_W-1:0] i_opcode,
  output class_t              o_class
);

  logic [10:0] w_op;

  // Classes are decided on the top 11 bits of the opcode field
  assign w_op = i_opcode[OPCODE_W-1 -: 11];

  // Priority match: exact opcodes first, then the short branch prefixes
  always_comb begin
    o_class = CL_ILLEGAL;
    if (w_op == OP_LDUR) begin
      o_class = CL_LDUR;
    end else if (w_op == OP_STUR) begin
      o_class = CL_STUR;
    end else if (w_op == OP_ADD || w_op == OP_SUB || w_op == OP_AND || w_op == OP_ORR) begin
      o_class = CL_RTYPE;
    end else if (w_op[10:3] == OP_CBZ) begin
      o_class = CL_CBZ;
    end else if (w_op[10:3] == OP_CBNZ && CBNZ_EN != 0) begin
      o_class = CL_CBNZ;
    end else if (w_op[10:5] == OP_B) begin
      o_class = CL_B;
    end
  end

endmodule

// File: rtl/multi_cycle_control.sv
// rtl/multi_cycle_control.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter int OPCODE_W = 11,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 32,
  parameter int CBNZ_EN  = 0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_zero,
  input  logic                i_mem_ready,
  output logic                o_pc_write,
  output logic                o_ir_write,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_reg_write,
  output logic                o_mem_to_reg,
  output logic                o_alu_src,
  output logic                o_reg2loc,
  output logic                o_uncond_branch,
  output logic [ALUOP_W-1:0]  o_alu_op,
  output logic                o_illegal,
  output logic                o_retired,
  output logic [CNT_W-1:0]    o_instr_count
);

  state_t           r_state;
  state_t           w_next;
  class_t           r_class;
  class_t           w_class;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       w_alu_op;

  opcode_class_decode #(
    .OPCODE_W (OPCODE_W),
    .CBNZ_EN  (CBNZ_EN)
  ) u_decode (
    .i_opcode (i_opcode),
    .o_class  (w_class)
  );

  assign o_alu_op      = ALUOP_W'(w_alu_op);
  assign o_instr_count = r_count;

  // State register, class latched in DECODE, and retired-instruction counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_FETCH;
      r_class <= CL_ILLEGAL;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_class <= w_class;
      end
      if (o_retired) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // Next state and controls; Zero/MemReady only gate PC/IR writes, retire and transitions
  always_comb begin
    w_next          = r_state;
    o_pc_write      = 1'b0;
    o_ir_write      = 1'b0;
    o_mem_read      = 1'b0;
    o_mem_write     = 1'b0;
    o_reg_write     = 1'b0;
    o_mem_to_reg    = 1'b0;
    o_alu_src       = 1'b0;
    o_reg2loc       = 1'b0;
    o_uncond_branch = 1'b0;
    o_illegal       = 1'b0;
    o_retired       = 1'b0;
    w_alu_op        = ALUOP_ADD;
    if (i_reset) begin
      // While reset is held the unit already looks like an idle FETCH
      o_mem_read = 1'b1;
      w_next     = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          o_mem_read = 1'b1;
          if (i_mem_ready) begin
            o_ir_write = 1'b1;
            o_pc_write = 1'b1;
            w_next     = S_DECODE;
          end
        end
        S_DECODE: begin
          w_next = (w_class == CL_ILLEGAL) ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          case (r_class)
            CL_LDUR: begin
              o_alu_src = 1'b1;
              w_next    = S_MEM;
            end
            CL_STUR: begin
              o_alu_src = 1'b1;
              o_reg2loc = 1'b1;
              w_next    = S_MEM;
            end
            CL_RTYPE: begin
              w_alu_op = ALUOP_FUNCT;
              w_next   = S_WB;
            end
            CL_CBZ, CL_CBNZ: begin
              o_reg2loc  = 1'b1;
              w_alu_op   = ALUOP_PASS;
              o_pc_write = (r_class == CL_CBZ) ? i_zero : ~i_zero;
              o_retired  = 1'b1;
              w_next     = S_FETCH;
            end
            CL_B: begin
              o_uncond_branch = 1'b1;
              o_pc_write      = 1'b1;
              o_retired       = 1'b1;
              w_next          = S_FETCH;
            end
            default: w_next = S_TRAP;
          endcase
        end
        S_MEM: begin
          o_mem_read  = (r_class == CL_LDUR);
          o_mem_write = (r_class == CL_STUR);
          if (i_mem_ready) begin
            o_retired = (r_class == CL_STUR);
            w_next    = (r_class == CL_LDUR) ? S_WB : S_FETCH;
          end
        end
        S_WB: begin
          o_reg_write  = 1'b1;
          o_mem_to_reg = (r_class == CL_LDUR);
          o_retired    = 1'b1;
          w_next       = S_FETCH;
        end
        S_TRAP: begin
          o_illegal = 1'b1;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb/tb_multi_cycle_control.sv - self-checking bench for multi_cycle_control
module tb_multi_cycle_control;

  localparam int K_ILL = 0, K_LD = 1, K_ST = 2, K_RT = 3, K_CBZ = 4, K_CBNZ = 5, K_B = 6;

  typedef struct packed {
    logic       pc, ir, mrd, mwr, rw, m2r, asrc, r2l, ub;
    logic [1:0] aop;
    logic       ill, ret;
  } ctl_t;

  typedef struct {
    logic [10:0] op;
    int          fw, mw, zmode;
    bit          on_b;
    int          exp_lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] opcode;
  logic        zero, mem_ready;

  logic a_pc, a_ir, a_mrd, a_mwr, a_rw, a_m2r, a_asrc, a_r2l, a_ub, a_ill, a_ret;
  logic b_pc, b_ir, b_mrd, b_mwr, b_rw, b_m2r, b_asrc, b_r2l, b_ub, b_ill, b_ret;
  logic [1:0] a_aop, b_aop;
  logic [3:0] a_cnt;
  logic [7:0] b_cnt;
  ctl_t a_ctl, b_ctl;

  int n_cmp = 0, n_bad = 0;
  int m_cnt_a = 0, m_cnt_b = 0;

  always #5 clk = ~clk;

  multi_cycle_control #(.OPCODE_W(11), .ALUOP_W(2), .CNT_W(4), .CBNZ_EN(0)) u_dut_a (
    .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_pc_write(a_pc), .o_ir_write(a_ir), .o_mem_read(a_mrd), .o_mem_write(a_mwr),
    .o_reg_write(a_rw), .o_mem_to_reg(a_m2r), .o_alu_src(a_asrc), .o_reg2loc(a_r2l),
    .o_uncond_branch(a_ub), .o_alu_op(a_aop), .o_illegal(a_ill), .o_retired(a_ret),
    .o_instr_count(a_cnt));

  multi_cycle_control #(.OPCODE_W(11), .ALUOP_W(2), .CNT_W(8), .CBNZ_EN(1)) u_dut_b (
    .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_pc_write(b_pc), .o_ir_write(b_ir), .o_mem_read(b_mrd), .o_mem_write(b_mwr),
    .o_reg_write(b_rw), .o_mem_to_reg(b_m2r), .o_alu_src(b_asrc), .o_reg2loc(b_r2l),
    .o_uncond_branch(b_ub), .o_alu_op(b_aop), .o_illegal(b_ill), .o_retired(b_ret),
    .o_instr_count(b_cnt));

  assign a_ctl = {a_pc, a_ir, a_mrd, a_mwr, a_rw, a_m2r, a_asrc, a_r2l, a_ub, a_aop, a_ill, a_ret};
  assign b_ctl = {b_pc, b_ir, b_mrd, b_mwr, b_rw, b_m2r, b_asrc, b_r2l, b_ub, b_aop, b_ill, b_ret};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input logic [10:0] op, input bit cbnz);
    if (op == 11'b11111000010) return K_LD;
    if (op == 11'b11111000000) return K_ST;
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return K_RT;
    if (op[10:3] == 8'b10110100) return K_CBZ;
    if (op[10:3] == 8'b10110101) return cbnz ? K_CBNZ : K_ILL;
    if (op[10:5] == 6'b000101) return K_B;
    return K_ILL;
  endfunction

  // Controls each step of an instruction must show, straight from the control table
  function automatic ctl_t exp_ctl(input byte s, input int c, input logic z);
    ctl_t e;
    e = '0;
    case (s)
      "f": e.mrd = 1'b1;
      "F": begin e.mrd = 1'b1; e.pc = 1'b1; e.ir = 1'b1; end
      "E": begin
        case (c)
          K_LD:   e.asrc = 1'b1;
          K_ST:   begin e.asrc = 1'b1; e.r2l = 1'b1; end
          K_RT:   e.aop = 2'b10;
          K_CBZ:  begin e.r2l = 1'b1; e.aop = 2'b01; e.pc = z; e.ret = 1'b1; end
          K_CBNZ: begin e.r2l = 1'b1; e.aop = 2'b01; e.pc = !z; e.ret = 1'b1; end
          K_B:    begin e.ub = 1'b1; e.pc = 1'b1; e.ret = 1'b1; end
          default: e = '0;
        endcase
      end
      "m": begin e.mrd = (c == K_LD); e.mwr = (c == K_ST); end
      "M": begin e.mrd = (c == K_LD); e.mwr = (c == K_ST); e.ret = (c == K_ST); end
      "W": begin e.rw = 1'b1; e.m2r = (c == K_LD); e.ret = 1'b1; end
      "T": e.ill = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [10:0] rand_op(input int sel);
    logic [10:0] r;
    r = 11'($urandom);
    case (sel)
      0: return 11'b11111000010;
      1: return 11'b11111000000;
      2: return 11'b10001011000;
      3: return 11'b11001011000;
      4: return 11'b10001010000;
      5: return 11'b10101010000;
      6: return {8'b10110100, r[2:0]};
      7: return {8'b10110101, r[2:0]};
      default: return {6'b000101, r[4:0]};
    endcase
  endfunction

  // Runs one instruction as a list of steps; lat is the DUT cycle count up to its Retired pulse
  task automatic run_instr(input bit on_b, input logic [10:0] op, input int fw, input int mw,
                           input int zmode, input int stop_after, output int lat);
    byte  steps[$];
    int   c;
    ctl_t e, act;
    c = classify(op, on_b);
    lat = -1;
    for (int k = 0; k < fw; k++) steps.push_back("f");
    steps.push_back("F");
    steps.push_back("D");
    if (c == K_ILL) begin
      for (int k = 0; k < 10; k++) steps.push_back("T");
    end else begin
      steps.push_back("E");
      if (c == K_LD || c == K_ST) begin
        for (int k = 0; k < mw; k++) steps.push_back("m");
        steps.push_back("M");
      end
      if (c == K_LD || c == K_RT) steps.push_back("W");
    end
    for (int i = 0; i < steps.size(); i++) begin
      if (stop_after >= 0 && i >= stop_after) break;
      @(negedge clk);
      opcode    = (steps[i] == "f" || steps[i] == "F") ? 11'($urandom) : op;
      mem_ready = (steps[i] == "F" || steps[i] == "M") ? 1'b1 :
                  (steps[i] == "f" || steps[i] == "m") ? 1'b0 : 1'($urandom);
      zero      = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      #1;
      e   = exp_ctl(steps[i], c, zero);
      act = on_b ? b_ctl : a_ctl;
      check(on_b ? "ctl_b" : "ctl_a", 32'(act), 32'(e));
      if (on_b) check("cnt_b", 32'(b_cnt), 32'(m_cnt_b & 255));
      else      check("cnt_a", 32'(a_cnt), 32'(m_cnt_a & 15));
      if (act.ret && lat < 0) lat = i + 1;
      if (e.ret) begin
        if (on_b) m_cnt_b++;
        else      m_cnt_a++;
      end
    end
  endtask

  task automatic do_reset();
    ctl_t idle;
    idle = '0;
    idle.mrd = 1'b1;
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'($urandom);
    zero      = 1'($urandom);
    opcode    = 11'($urandom);
    #1;
    check("rst_ctl_a", 32'(a_ctl), 32'(idle));
    check("rst_ctl_b", 32'(b_ctl), 32'(idle));
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("post_rst_ctl_a", 32'(a_ctl), 32'(idle));
    check("post_rst_ctl_b", 32'(b_ctl), 32'(idle));
    check("post_rst_cnt_a", 32'(a_cnt), 32'd0);
    check("post_rst_cnt_b", 32'(b_cnt), 32'd0);
    m_cnt_a = 0;
    m_cnt_b = 0;
  endtask

  vec_t vecs[$];
  int   lat;
  bit   prev_b;

  initial begin
    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    vecs.push_back('{11'b10001011000, 0, 0, 2, 1'b0, 4});
    vecs.push_back('{11'b11111000010, 0, 2, 2, 1'b0, 7});
    vecs.push_back('{11'b10110100000, 0, 0, 1, 1'b0, 3});
    vecs.push_back('{11'b10110100000, 0, 0, 0, 1'b0, 3});
    vecs.push_back('{11'b11111000000, 0, 0, 2, 1'b0, 4});
    vecs.push_back('{11'b11001011000, 1, 0, 2, 1'b0, 5});
    vecs.push_back('{11'b10101010000, 0, 0, 2, 1'b0, 4});
    vecs.push_back('{11'b10001010000, 0, 0, 2, 1'b0, 4});
    vecs.push_back('{11'b00010100011, 0, 0, 2, 1'b0, 3});
    vecs.push_back('{11'b11111000010, 2, 1, 2, 1'b0, 8});
    vecs.push_back('{11'b11111000000, 0, 3, 2, 1'b0, 7});
    vecs.push_back('{11'b10110101000, 0, 0, 0, 1'b1, 3});
    vecs.push_back('{11'b10110101111, 0, 0, 1, 1'b1, 3});
    vecs.push_back('{11'b11111000010, 0, 0, 2, 1'b1, 5});
    prev_b = 1'b0;
    foreach (vecs[i]) begin
      if (vecs[i].on_b != prev_b) do_reset();
      prev_b = vecs[i].on_b;
      run_instr(vecs[i].on_b, vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].zmode, -1, lat);
      check($sformatf("latency_%0d", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Sixteen B instructions wrap a 4-bit counter back to zero
    do_reset();
    for (int i = 0; i < 16; i++) run_instr(1'b0, 11'b00010100000, 0, 0, 2, -1, lat);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("wrap_cnt", 32'(a_cnt), 32'd0);
    check("wrap_idle_ctl", 32'(a_ctl), 32'h400);

    // Reset during a STUR memory wait drops MemWrite and clears the count
    run_instr(1'b0, 11'b10001011000, 0, 0, 2, -1, lat);
    run_instr(1'b0, 11'b11111000000, 0, 5, 2, 4, lat);
    check("stur_mem_write", 32'(a_mwr), 32'd1);
    do_reset();
    check("stur_rst_mem_write", 32'(a_mwr), 32'd0);

    // Illegal CBNZ-shaped opcode traps when CBNZ is disabled; only reset escapes
    run_instr(1'b0, 11'b10110101000, 0, 0, 2, -1, lat);
    check("trap_no_retire", 32'(lat), 32'hFFFF_FFFF);
    do_reset();
    run_instr(1'b0, 11'b10001011000, 0, 0, 2, -1, lat);
    check("after_trap_lat", 32'(lat), 32'd4);

    // Random instruction stream with random fetch/memory waits on the CBNZ-enabled unit
    do_reset();
    for (int i = 0; i < 150; i++) begin
      run_instr(1'b1, rand_op($urandom_range(0, 8)), $urandom_range(0, 2),
                $urandom_range(0, 2), 2, -1, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 Parameter OPCODE_W, default 11: opcode field width.
REQ-002 Parameter ALUOP_W, default 2: ALUOp width.
REQ-003 Parameter CNT_W, default 32: retired-instruction counter width.
REQ-004 Parameter CBNZ_EN, default 0: when 1, opcode 10110101??? is decoded as CBNZ; when 0 it is illegal.
REQ-005 CLK  in  1  single clock; all state changes on the rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 Opcode  in  OPCODE_W  instruction opcode from the instruction register, valid from DECODE onward.
REQ-008 Zero  in  1  ALU zero flag, sampled in EXEC.
REQ-009 MemReady  in  1  memory-done handshake, sampled in FETCH and MEM.
REQ-010 PCWrite, IRWrite, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc, Reg2Loc, Uncondbranch  out  1 each  datapath controls.
REQ-011 ALUOp  out  ALUOP_W  00 add, 01 pass/compare-zero, 10 funct-decoded.
REQ-012 Illegal  out  1  high while trapped on an undecodable opcode.
REQ-013 Retired  out  1  one-cycle pulse on the final cycle of each instruction.
REQ-014 InstrCount  out  CNT_W  count of retired instructions.

Function
REQ-015 States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
REQ-016 FETCH: assert MemRead. Stay while MemReady=0. On MemReady=1, assert IRWrite and PCWrite (PC+4) and go to DECODE.
REQ-017 DECODE: latch the opcode class (LDUR, STUR, RTYPE for ADD/SUB/AND/ORR, CBZ, CBNZ, B, ILLEGAL). ILLEGAL goes to TRAP; all others go to EXEC.
REQ-018 EXEC controls:
- LDUR/STUR: ALUSrc=1, ALUOp=00; Reg2Loc=1 for STUR.
- RTYPE: ALUSrc=0, Reg2Loc=0, ALUOp=10.
- CBZ/CBNZ: Reg2Loc=1, ALUOp=01.
- B: Uncondbranch=1.
REQ-019 EXEC next state: LDUR/STUR go to MEM; RTYPE goes to WB; branches go to FETCH.
REQ-020 Branch PCWrite in EXEC: B asserts it unconditionally; CBZ asserts it iff Zero=1; CBNZ asserts it iff Zero=0.
REQ-021 MEM: LDUR asserts MemRead, STUR asserts MemWrite. Hold MemRead/MemWrite and stay in MEM while MemReady=0. On MemReady=1, LDUR goes to WB and STUR goes to FETCH.
REQ-022 WB: RegWrite=1; MemToReg=1 for LDUR, 0 for RTYPE; then go to FETCH.
REQ-023 Latency with MemReady tied to 1:
- B, CBZ, CBNZ: 3 cycles.
- RTYPE, STUR: 4 cycles.
- LDUR: 5 cycles.
Each wait cycle adds exactly one cycle.
REQ-024 Retired pulses on the exit cycle of EXEC (branches), MEM (STUR) and WB. InstrCount increments on that same edge and wraps from 2^CNT_W-1 to 0.
REQ-025 TRAP: Illegal=1, all other controls 0. Leave TRAP only by reset.
REQ-026 Any control not named for a state is driven 0, never x.
REQ-027 Outputs are a Moore function of state and latched class; Zero and MemReady affect only PCWrite/IRWrite and next-state.

Reset
REQ-028 Reset=1 at an edge forces FETCH, clears the latched class, and sets InstrCount=0.
REQ-029 Reset overrides any in-flight instruction, wait state or TRAP.
REQ-030 During reset and the cycle after it, outputs are all 0 except MemRead=1 (FETCH).

Structure
REQ-031 A shared package holds:
- opcode constants (LDUR, STUR, ADD, SUB, AND, ORR, CBZ, CBNZ, B);
- state and class enums;
- ALUOp encodings.
REQ-032 A combinational sub-module opcode_class_decode maps Opcode to class, honouring CBNZ_EN.

Verification
REQ-033 ADD (10001011000), MemReady=1 -> 4 cycles, RegWrite=1 and MemToReg=0 in WB, Retired once, InstrCount 0->1.
REQ-034 LDUR (11111000010) with MemReady low for 2 cycles in MEM -> 7 cycles total, MemRead held throughout MEM, MemToReg=1 in WB.
REQ-035 CBZ (10110100000) with Zero=1 then Zero=0 -> PCWrite in EXEC only for the first; 3 cycles each.
REQ-036 Opcode 10110101000 with CBNZ_EN=0 -> TRAP, Illegal stays 1 for 10 cycles, Reset returns to FETCH.
REQ-037 CNT_W=4, 16 B instructions -> InstrCount wraps to 0; Reset asserted in MEM of a STUR -> no MemWrite the next cycle, count 0.
